// File: rtl/instr_feeder.sv
// Instruction sequencer: fetches words from a small program RAM and drives them to the
// processor on DIN with a one-cycle Run strobe, pacing on Done with a timeout guard.
module instr_feeder #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [15:0]   i_wr_data,
  input  logic          i_done,
  output logic [15:0]   o_din,
  output logic          o_run,
  output logic [AW-1:0] o_pc,
  output logic          o_busy,
  output logic          o_halted,
  output logic          o_error,
  output logic [15:0]   o_instr_count
);
  localparam int         DEPTH   = 1 << AW;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_IMM, S_WAIT, S_HALTED, S_ERROR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_din, w_din_nxt;
  logic          r_run, w_run_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_halted, w_halted_nxt;
  logic          r_error, w_error_nxt;
  logic [15:0]   r_icnt, w_icnt_nxt;
  logic [7:0]    r_tcnt, w_tcnt_nxt;
  logic [7:0]    w_tcnt_inc;
  logic [AW-1:0] w_pc_p1, w_pc_p2;
  logic [15:0]   w_word, w_imm;

  assign w_pc_p1    = r_pc + AW'(1);
  assign w_pc_p2    = r_pc + AW'(2);
  assign w_word     = r_mem[r_pc];
  assign w_imm      = r_mem[w_pc_p1];
  assign w_tcnt_inc = r_tcnt + 8'd1;

  // Writes are only taken while idle, so the running program never changes underneath us.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !r_busy) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_din    <= '0;
      r_run    <= 1'b0;
      r_pc     <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
      r_icnt   <= '0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_din    <= w_din_nxt;
      r_run    <= w_run_nxt;
      r_pc     <= w_pc_nxt;
      r_busy   <= w_busy_nxt;
      r_halted <= w_halted_nxt;
      r_error  <= w_error_nxt;
      r_icnt   <= w_icnt_nxt;
      r_tcnt   <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_din_nxt    = r_din;
    w_run_nxt    = 1'b0;
    w_pc_nxt     = r_pc;
    w_halted_nxt = r_halted;
    w_error_nxt  = r_error;
    w_icnt_nxt   = r_icnt;
    w_tcnt_nxt   = r_tcnt;
    case (r_state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (i_start) begin
          w_state_nxt  = S_FETCH;
          w_pc_nxt     = '0;
          w_icnt_nxt   = '0;
          w_tcnt_nxt   = '0;
          w_halted_nxt = 1'b0;
          w_error_nxt  = 1'b0;
        end
      end
      S_FETCH: begin
        if (w_word[8:6] == OP_HALT) begin
          // HALT consumes its word so PC still names the next unfetched address
          w_state_nxt  = S_HALTED;
          w_halted_nxt = 1'b1;
          w_pc_nxt     = w_pc_p1;
        end else if (w_word[8:6] == OP_MVI && r_pc == AW'(DEPTH - 1)) begin
          w_state_nxt = S_ERROR;
          w_error_nxt = 1'b1;
        end else begin
          w_state_nxt = S_ISSUE;
          w_din_nxt   = w_word;
          w_run_nxt   = 1'b1;
          w_tcnt_nxt  = '0;
        end
      end
      S_ISSUE: begin
        if (r_din[8:6] == OP_MVI) begin
          w_state_nxt = S_IMM;
          w_din_nxt   = w_imm;
          w_pc_nxt    = w_pc_p2;
        end else begin
          w_state_nxt = S_WAIT;
          w_pc_nxt    = w_pc_p1;
        end
      end
      S_IMM, S_WAIT: begin
        if (i_done) begin
          w_icnt_nxt = r_icnt + 16'd1;
          w_tcnt_nxt = '0;
          if (r_pc == '0) begin
            w_state_nxt  = S_HALTED;
            w_halted_nxt = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_tcnt_nxt = w_tcnt_inc;
          if (r_state == S_IMM) begin
            w_state_nxt = S_WAIT;
          end else if (w_tcnt_inc == 8'(TIMEOUT)) begin
            w_state_nxt = S_ERROR;
            w_error_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_ISSUE) ||
                 (w_state_nxt == S_IMM)   || (w_state_nxt == S_WAIT);
  end

  assign o_din         = r_din;
  assign o_run         = r_run;
  assign o_pc          = r_pc;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;
  assign o_error       = r_error;
  assign o_instr_count = r_icnt;

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Instruction sequencer that drives the processor's instruction-side interface: the DIN word bus and the Run strobe.
- Consumes the processor's Done strobe.
- Holds a small program memory, loaded through a write port, and issues one instruction at a time.
- Supplies the immediate word for mvi.
- Sits between the host/test harness and the processor core, replacing manual DIN/Run switch stimulus.

Parameters:
- AW, 5, program memory address width; DEPTH = 2^AW words of 16 bits.
- TIMEOUT, 16, max cycles to wait for Done after an issue before flagging Error (range 2..255).

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  pulse: clear PC/counters and begin execution from address 0.
- WrEn  in  1  program memory write enable; honoured only when Busy=0.
- WrAddr  in  AW  program memory write address.
- WrData  in  16  program memory write data.
- Done  in  1  processor completion strobe.
- DIN  out  16  registered instruction/immediate word to the processor.
- Run  out  1  registered one-cycle strobe; instruction is valid on DIN in that cycle.
- PC  out  AW  address of the next word to fetch.
- Busy  out  1  high in every state except IDLE, HALTED and ERROR.
- Halted  out  1  program reached the HALT opcode or ran off the end of memory.
- Error  out  1  Done timeout, or mvi with no room for its immediate.
- InstrCount  out  16  instructions completed since Start; wraps at 16'hFFFF→0.

Behaviour:
- Instruction format: opcode = word[8:6], RX = word[5:3], RY = word[2:0]; bits [15:9] are passed through untouched.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT (never issued). Any other opcode is issued like mv.
- Reset: state IDLE; DIN=0, Run=0, PC=0, Busy=0, Halted=0, Error=0, InstrCount=0, timeout counter=0. Memory contents are not reset.
- All outputs are registered; no combinational path from Done to Run or DIN.
- States: IDLE, FETCH, ISSUE, IMM, WAIT, HALTED, ERROR.
- IDLE/HALTED/ERROR:
  - Start=1 → FETCH with PC=0, InstrCount=0, Halted=0, Error=0.
  - Start is ignored in all other states.
- FETCH (1 cycle), word w = mem[PC]:
  - opcode 111 → HALTED, Halted=1, Run stays 0.
  - opcode 001 with PC=DEPTH-1 → ERROR, Error=1.
  - otherwise load DIN=w, Run=1 → ISSUE.
- ISSUE (Run=1 exactly this cycle):
  - mvi: DIN ← mem[PC+1], PC += 2 → IMM.
  - otherwise: PC += 1 → WAIT.
  - Done is ignored in ISSUE.
- IMM: Run=0, DIN holds the immediate. Done=1 → completion; else → WAIT.
- WAIT: Run=0, DIN held. Done=1 → completion. Otherwise the timeout counter increments; reaching TIMEOUT → ERROR, Error=1.
- Completion:
  - InstrCount += 1, timeout counter cleared.
  - If PC wrapped to 0 (last word consumed) → HALTED, Halted=1; else → FETCH.
- Timeout counter is cleared on entry to ISSUE; it counts IMM and WAIT cycles.
- Minimum issue period: mv/add/sub with Done in the first WAIT cycle gives 3 cycles per instruction (FETCH, ISSUE, WAIT).
- Write port:
  - WrEn while Busy=1 is dropped; it does not stall.
  - A write in the same cycle as a Start that is accepted lands before the first FETCH.
- Reset asserted mid-instruction: immediate return to reset values; Run drops asynchronously.
- Done asserted while in IDLE/HALTED/ERROR: ignored.

Test Plan:
- Load mem[0]=16'h0008 (mv R1,R0), mem[1]=16'h01C0 (HALT); pulse Start; drive Done 1 cycle after Run → Run high exactly 1 cycle with DIN=16'h0008, then Halted=1, InstrCount=1, PC=2, Busy=0.
- Load mem[0]=16'h0040 (mvi R0), mem[1]=16'h00A5, mem[2]=HALT; Done in the IMM cycle → DIN=16'h0040 in the Run cycle, DIN=16'h00A5 the following cycle, InstrCount=1, Halted=1.
- Program mv, add (16'h0091), sub (16'h00D1), HALT; Done 2 cycles after each Run → three Run pulses with those DIN values in order, InstrCount=3.
- Program mem[0]=mv; Done never asserted, TIMEOUT=16 → Error=1 exactly 16 cycles after the WAIT count starts, Busy=0, Run=0.
- Fill all 32 words with mv; Done every issue → Halted=1 after the 32nd completion, PC=0, InstrCount=32.
- Mid-WAIT: assert Reset asynchronously; also pulse WrEn while Busy → all outputs at reset values; the dropped write leaves memory unchanged (verified by re-run).
